// File: rtl/tour_length_if.sv
// Bus bundle between tour_length, its tour/coordinate memories, the distance
// pipeline and the controlling FSM.
interface tour_length_if #(
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned SUM_W   = 32
);
  logic               start;
  logic [IDX_W:0]     n_cities;
  logic [IDX_W-1:0]   tour_addr;
  logic [IDX_W-1:0]   tour_idx;
  logic [IDX_W-1:0]   coord_addr;
  logic [COORD_W-1:0] coord_x;
  logic [COORD_W-1:0] coord_y;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic [COORD_W-1:0] x2;
  logic [COORD_W-1:0] y2;
  logic [31:0]        res;
  logic               busy;
  logic               done;
  logic [SUM_W-1:0]   total;

  // tour_length side
  modport slave (
    input  start, n_cities, tour_idx, coord_x, coord_y, res,
    output tour_addr, coord_addr, x1, y1, x2, y2, busy, done, total
  );

  // environment side: requester, memories and distance pipeline
  modport master (
    output start, n_cities, tour_idx, coord_x, coord_y, res,
    input  tour_addr, coord_addr, x1, y1, x2, y2, busy, done, total
  );
endinterface

// File: rtl/tour_length.sv
// Closed-tour length: walks the tour memory, streams consecutive coordinate
// pairs into the distance pipeline and sums the returned distances.
module tour_length #(
  parameter int unsigned N_MAX    = 64,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned DIST_LAT = 10,
  parameter int unsigned SUM_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  tour_length_if.slave bus
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] N_MAX_C = CNT_W'(N_MAX);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [IDX_W-1:0]   tour_addr_q, tour_addr_d;
  logic [1:0]         fv_q, fv_d;
  logic               prev_ok_q, prev_ok_d;
  logic [COORD_W-1:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic               pair_v_q, pair_v_d;
  logic [DIST_LAT-1:0] iv_q, iv_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [SUM_W-1:0]   total_q, total_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   n_eff_c;
  logic [SUM_W-1:0]   sum_c;
  logic               res_v_c;
  logic               last_edge_c;

  // Requested length clamped to the tour memory size
  assign n_eff_c     = (bus.n_cities > N_MAX_C) ? N_MAX_C : bus.n_cities;
  assign res_v_c     = iv_q[DIST_LAT-1];
  assign sum_c       = acc_q + SUM_W'(bus.res);
  assign last_edge_c = res_v_c && ((edge_cnt_q + CNT_W'(1)) == n_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    addr_cnt_d  = addr_cnt_q;
    tour_addr_d = tour_addr_q;
    prev_ok_d   = prev_ok_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    x2_d        = x2_q;
    y2_d        = y2_q;
    pair_v_d    = 1'b0;
    acc_d       = acc_q;
    edge_cnt_d  = edge_cnt_q;
    total_d     = total_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // bit 0: tour_idx valid, bit 1: coordinate valid
    fv_d        = {fv_q[0], (state_q == FETCH)};
    iv_d        = (iv_q << 1) | DIST_LAT'(pair_v_q);

    // First coordinate seeds prev; each later one issues a pair
    if (fv_q[1]) begin
      prev_x_d = bus.coord_x;
      prev_y_d = bus.coord_y;
      if (!prev_ok_q) begin
        prev_ok_d = 1'b1;
      end else begin
        x1_d     = prev_x_q;
        y1_d     = prev_y_q;
        x2_d     = bus.coord_x;
        y2_d     = bus.coord_y;
        pair_v_d = 1'b1;
      end
    end

    if (res_v_c) begin
      acc_d      = sum_c;
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d         = n_eff_c;
          acc_d       = '0;
          edge_cnt_d  = '0;
          addr_cnt_d  = '0;
          tour_addr_d = '0;
          prev_ok_d   = 1'b0;
          busy_d      = 1'b1;
          state_d     = (n_eff_c < CNT_W'(2)) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        // addresses 0..n-1 then 0 again to close the tour
        if (addr_cnt_q == n_q) begin
          tour_addr_d = '0;
          state_d     = DRAIN;
        end else begin
          addr_cnt_d  = addr_cnt_q + CNT_W'(1);
          tour_addr_d = ((addr_cnt_q + CNT_W'(1)) == n_q) ? '0
                        : IDX_W'(addr_cnt_q + CNT_W'(1));
        end
      end
      DRAIN: begin
        if (n_q < CNT_W'(2)) begin
          total_d = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else if (last_edge_c) begin
          total_d = sum_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q         <= '0;
      addr_cnt_q  <= '0;
      tour_addr_q <= '0;
      fv_q        <= '0;
      prev_ok_q   <= 1'b0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      x2_q        <= '0;
      y2_q        <= '0;
      pair_v_q    <= 1'b0;
      iv_q        <= '0;
      acc_q       <= '0;
      edge_cnt_q  <= '0;
      total_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      n_q         <= n_d;
      addr_cnt_q  <= addr_cnt_d;
      tour_addr_q <= tour_addr_d;
      fv_q        <= fv_d;
      prev_ok_q   <= prev_ok_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      pair_v_q    <= pair_v_d;
      iv_q        <= iv_d;
      acc_q       <= acc_d;
      edge_cnt_q  <= edge_cnt_d;
      total_q     <= total_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.tour_addr  = tour_addr_q;
  assign bus.coord_addr = bus.tour_idx;
  assign bus.x1         = x1_q;
  assign bus.y1         = y1_q;
  assign bus.x2         = x2_q;
  assign bus.y2         = y2_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.total      = total_q;

endmodule

// File: tb/tb_tour_length.sv
// Bench for tour_length: behavioural memories and distance pipeline, tour
// length reference computed directly from city coordinates.
module tb_tour_length;
  localparam int unsigned N_MAX    = 64;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned COORD_W  = 8;
  localparam int unsigned DIST_LAT = 10;
  localparam int unsigned SUM_W    = 32;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  tour_length_if #(.IDX_W(IDX_W), .COORD_W(COORD_W), .SUM_W(SUM_W)) bus ();

  tour_length #(.N_MAX(N_MAX), .IDX_W(IDX_W), .COORD_W(COORD_W),
                .DIST_LAT(DIST_LAT), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [IDX_W-1:0]   tour_mem [N_MAX];
  logic [COORD_W-1:0] cx [N_MAX];
  logic [COORD_W-1:0] cy [N_MAX];
  logic [31:0]        dpipe [DIST_LAT];

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int edge_len(input int ax, input int ay, input int bx, input int by);
    return isqrt((ax - bx) * (ax - bx) + (ay - by) * (ay - by));
  endfunction

  // Reference: sum of floor-sqrt edge lengths around the closed tour
  function automatic int ref_len(input int n);
    int s = 0;
    int a, b;
    if (n < 2) return 0;
    for (int k = 0; k < n; k++) begin
      a = int'(tour_mem[k]);
      b = int'(tour_mem[(k + 1) % n]);
      s += edge_len(int'(cx[a]), int'(cy[a]), int'(cx[b]), int'(cy[b]));
    end
    return s;
  endfunction

  // Synchronous-read tour and coordinate memories
  always @(posedge clk) begin
    bus.tour_idx <= tour_mem[bus.tour_addr];
    bus.coord_x  <= cx[bus.coord_addr];
    bus.coord_y  <= cy[bus.coord_addr];
  end

  // Behavioural distance pipeline
  always @(posedge clk) begin
    dpipe[0] <= 32'(edge_len(int'(bus.x1), int'(bus.y1), int'(bus.x2), int'(bus.y2)));
    for (int i = 1; i < int'(DIST_LAT); i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.res = dpipe[DIST_LAT-1];

  task automatic load_three;
    cx[0] = 8'd0; cy[0] = 8'd0;
    cx[1] = 8'd3; cy[1] = 8'd4;
    cx[2] = 8'd0; cy[2] = 8'd4;
    tour_mem[0] = 6'd0; tour_mem[1] = 6'd1; tour_mem[2] = 6'd2;
  endtask

  task automatic load_square;
    cx[0] = 8'd0;  cy[0] = 8'd0;
    cx[1] = 8'd30; cy[1] = 8'd0;
    cx[2] = 8'd30; cy[2] = 8'd40;
    cx[3] = 8'd0;  cy[3] = 8'd40;
    tour_mem[0] = 6'd0; tour_mem[1] = 6'd2; tour_mem[2] = 6'd1; tour_mem[3] = 6'd3;
  endtask

  // Start a run (entered #1 after a rising edge) and measure done latency
  task automatic do_run(input int n_req, input bit mid_start, output int lat,
                        output bit got, output logic [SUM_W-1:0] tot, output int width);
    bus.start    = 1'b1;
    bus.n_cities = 7'(n_req);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; got = 1'b0; tot = '0; width = 0;
    for (int c = 1; c <= 400 && !got; c++) begin
      if (mid_start && c == 5) begin
        bus.start = 1'b1; bus.n_cities = 7'd2;
      end else if (mid_start && c == 6) begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        got = 1'b1; lat = c; tot = bus.total; width = 1;
      end
    end
    bus.start = 1'b0;
    if (got) begin
      @(posedge clk); #1;
      if (bus.done) width = 2;
    end
  endtask

  task automatic test_reset;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy=%0b done=%0b want 0 0", bus.busy, bus.done);
    end
    tests_run++;
    if (bus.total !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_total: got %0d want 0", bus.total);
    end
    tests_run++;
    if (bus.tour_addr !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_tour_addr: got %0d want 0", bus.tour_addr);
    end
    tests_run++;
    if ({bus.x1, bus.y1, bus.x2, bus.y2} !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_operands: got %h want 0", {bus.x1, bus.y1, bus.x2, bus.y2});
    end
  endtask

  task automatic test_three_cities;
    int lat, width; bit got; logic [SUM_W-1:0] tot;
    load_three();
    tests_run++;
    if (ref_len(3) != 12) begin
      tests_failed++;
      $display("FAIL three_ref: got %0d want 12", ref_len(3));
    end
    do_run(3, 1'b0, lat, got, tot, width);
    tests_run++;
    if (!got || tot !== 32'd12) begin
      tests_failed++;
      $display("FAIL three_total: done=%0b total=%0d want 12", got, tot);
    end
    tests_run++;
    if (lat != 17) begin
      tests_failed++;
      $display("FAIL three_latency: got %0d want 17", lat);
    end
    tests_run++;
    if (width != 1) begin
      tests_failed++;
      $display("FAIL three_done_width: got %0d want 1", width);
    end
  endtask

  task automatic test_square;
    int lat, width; bit got; logic [SUM_W-1:0] tot;
    load_square();
    do_run(4, 1'b0, lat, got, tot, width);
    tests_run++;
    if (!got || tot !== 32'd180) begin
      tests_failed++;
      $display("FAIL square_total: done=%0b total=%0d want 180", got, tot);
    end
    tests_run++;
    if (lat != 18 || width != 1) begin
      tests_failed++;
      $display("FAIL square_timing: latency=%0d width=%0d want 18 1", lat, width);
    end
  endtask

  task automatic test_small_n;
    int lat, width; bit got; logic [SUM_W-1:0] tot;
    logic [31:0] ops;
    for (int n = 1; n >= 0; n--) begin
      ops = {bus.x1, bus.y1, bus.x2, bus.y2};
      do_run(n, 1'b0, lat, got, tot, width);
      tests_run++;
      if (!got || tot !== 32'd0 || lat != 1 || width != 1) begin
        tests_failed++;
        $display("FAIL small_n%0d: done=%0b total=%0d latency=%0d width=%0d want 1 0 1 1",
                 n, got, tot, lat, width);
      end
      repeat (15) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.x1, bus.y1, bus.x2, bus.y2} !== ops || bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL small_n%0d_quiet: operands=%h done=%0b want %h 0",
                 n, {bus.x1, bus.y1, bus.x2, bus.y2}, bus.done, ops);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, width; bit got; logic [SUM_W-1:0] tot;
    load_square();
    do_run(4, 1'b1, lat, got, tot, width);
    tests_run++;
    if (!got || tot !== 32'd180 || lat != 18) begin
      tests_failed++;
      $display("FAIL midstart_run: done=%0b total=%0d latency=%0d want 180 18", got, tot, lat);
    end
    load_three();
    do_run(3, 1'b0, lat, got, tot, width);
    tests_run++;
    if (!got || tot !== 32'd12 || lat != 17) begin
      tests_failed++;
      $display("FAIL back_to_back: done=%0b total=%0d latency=%0d want 12 17", got, tot, lat);
    end
  endtask

  task automatic test_reset_mid_drain;
    int lat, width; bit got; logic [SUM_W-1:0] tot;
    load_square();
    bus.start = 1'b1; bus.n_cities = 7'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.total !== 32'd0 ||
        {bus.x1, bus.y1, bus.x2, bus.y2} !== 32'd0) begin
      tests_failed++;
      $display("FAIL midrst_values: busy=%0b done=%0b total=%0d ops=%h want 0",
               bus.busy, bus.done, bus.total, {bus.x1, bus.y1, bus.x2, bus.y2});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    load_three();
    do_run(3, 1'b0, lat, got, tot, width);
    tests_run++;
    if (!got || tot !== 32'd12 || lat != 17) begin
      tests_failed++;
      $display("FAIL midrst_rerun: done=%0b total=%0d latency=%0d want 12 17", got, tot, lat);
    end
  endtask

  task automatic test_random;
    int lat, width, n, j, t, exp; bit got; logic [SUM_W-1:0] tot;
    int perm [N_MAX];
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'(N_MAX); i++) begin
        perm[i] = i;
        cx[i] = 8'($urandom_range(255, 0));
        cy[i] = 8'($urandom_range(255, 0));
      end
      for (int i = int'(N_MAX) - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < int'(N_MAX); i++) tour_mem[i] = 6'(perm[i]);
      n = (r == 0) ? 2 : (r == 1) ? int'(N_MAX) : int'($urandom_range(N_MAX, 2));
      exp = ref_len(n);
      do_run(n, 1'b0, lat, got, tot, width);
      tests_run++;
      if (!got || tot !== 32'(exp) || lat != n + int'(DIST_LAT) + 4) begin
        tests_failed++;
        $display("FAIL random_n%0d: done=%0b total=%0d latency=%0d want %0d %0d",
                 n, got, tot, lat, exp, n + int'(DIST_LAT) + 4);
      end
    end
  endtask

  task automatic test_clamp;
    int lat, width, exp; bit got; logic [SUM_W-1:0] tot;
    exp = ref_len(int'(N_MAX));
    do_run(100, 1'b0, lat, got, tot, width);
    tests_run++;
    if (!got || tot !== 32'(exp) || lat != int'(N_MAX) + int'(DIST_LAT) + 4) begin
      tests_failed++;
      $display("FAIL clamp: done=%0b total=%0d latency=%0d want %0d %0d",
               got, tot, lat, exp, int'(N_MAX) + int'(DIST_LAT) + 4);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.n_cities = '0;
    for (int i = 0; i < int'(N_MAX); i++) begin
      tour_mem[i] = 6'(i); cx[i] = '0; cy[i] = '0;
    end
    for (int i = 0; i < int'(DIST_LAT); i++) dpipe[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_three_cities();
    test_square();
    test_small_n();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
